// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared decode encodings and the bubble control bundle for the ID/EX register
package id_ex_stage_pkg;
  localparam logic [1:0] REGDST_RD = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_LINK = 2'b10;
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;
  localparam logic [3:0] ALUOP_NOP = 4'b0000;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0011;
  localparam logic [3:0] ALUOP_AND = 4'b0100;
  localparam logic [3:0] ALUOP_OR = 4'b0101;
  localparam logic [3:0] ALUOP_SLT = 4'b0110;
  localparam logic [3:0] ALUOP_LUI = 4'b0111;
  typedef struct packed {
    logic       valid;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [3:0] aluop;
    logic       regwrite;
    logic       alusrc;
    logic       memwrite;
    logic       memread;
    logic       branch;
    logic       jump;
    logic       jumpmux;
  } ctrl_t;
  localparam ctrl_t BUBBLE_CTRL = '{
    valid: 1'b0, regdst: REGDST_RD, memtoreg: MEMTOREG_ALU, aluop: ALUOP_NOP,
    regwrite: 1'b0, alusrc: 1'b0, memwrite: 1'b0, memread: 1'b0,
    branch: 1'b0, jump: 1'b0, jumpmux: 1'b0
  };
endpackage

// File: rtl/id_ex_stage_load_use_detector.sv
// load_use_detector: flags an ID instruction that reads the register a load in EX is still fetching
module load_use_detector
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_valid,
  input  logic                      ex_memread,
  input  logic [REG_ADDR_WIDTH-1:0] ex_writereg,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_usesrt,
  output logic                      hazard
);
  assign hazard = ex_valid & ex_memread & (|ex_writereg) & id_valid &
                  ((ex_writereg == id_rs) | (id_usesrt & (ex_writereg == id_rt)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush, hold and bubble counting
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16,
  parameter int LINK_REG       = 31
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      ID_Valid,
  input  logic [1:0]                ID_RegDst,
  input  logic [1:0]                ID_MemToReg,
  input  logic [3:0]                ID_AluOp,
  input  logic                      ID_RegWrite,
  input  logic                      ID_AluSrc,
  input  logic                      ID_MemWrite,
  input  logic                      ID_MemRead,
  input  logic                      ID_Branch,
  input  logic                      ID_Jump,
  input  logic                      ID_JumpMux,
  input  logic [DATA_WIDTH-1:0]     ID_ReadData1,
  input  logic [DATA_WIDTH-1:0]     ID_ReadData2,
  input  logic [DATA_WIDTH-1:0]     ID_Imm,
  input  logic [DATA_WIDTH-1:0]     ID_PCPlus4,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rs,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rt,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rd,
  input  logic                      ID_UsesRt,
  input  logic                      Flush,
  input  logic                      Hold,
  output logic                      EX_Valid,
  output logic [1:0]                EX_RegDst,
  output logic [1:0]                EX_MemToReg,
  output logic [3:0]                EX_AluOp,
  output logic                      EX_RegWrite,
  output logic                      EX_AluSrc,
  output logic                      EX_MemWrite,
  output logic                      EX_MemRead,
  output logic                      EX_Branch,
  output logic                      EX_Jump,
  output logic                      EX_JumpMux,
  output logic [DATA_WIDTH-1:0]     EX_ReadData1,
  output logic [DATA_WIDTH-1:0]     EX_ReadData2,
  output logic [DATA_WIDTH-1:0]     EX_Imm,
  output logic [DATA_WIDTH-1:0]     EX_PCPlus4,
  output logic [REG_ADDR_WIDTH-1:0] EX_Rs,
  output logic [REG_ADDR_WIDTH-1:0] EX_Rt,
  output logic [REG_ADDR_WIDTH-1:0] EX_Rd,
  output logic [REG_ADDR_WIDTH-1:0] EX_WriteReg,
  output logic                      Stall,
  output logic [CNT_WIDTH-1:0]      BubbleCount
);
  localparam logic [REG_ADDR_WIDTH-1:0] LINK = REG_ADDR_WIDTH'(LINK_REG);
  ctrl_t id_ctrl, ex_ctrl;
  logic hazard, load, count;
  logic [REG_ADDR_WIDTH-1:0] dest;
  assign id_ctrl = '{
    valid: ID_Valid, regdst: ID_RegDst, memtoreg: ID_MemToReg, aluop: ID_AluOp,
    regwrite: ID_RegWrite, alusrc: ID_AluSrc, memwrite: ID_MemWrite, memread: ID_MemRead,
    branch: ID_Branch, jump: ID_Jump, jumpmux: ID_JumpMux
  };
  assign {EX_Valid, EX_RegDst, EX_MemToReg, EX_AluOp, EX_RegWrite, EX_AluSrc,
          EX_MemWrite, EX_MemRead, EX_Branch, EX_Jump, EX_JumpMux} = ex_ctrl;
  assign dest = !ID_RegWrite ? '0 :
                ID_RegDst == REGDST_RT ? ID_Rt :
                ID_RegDst == REGDST_LINK ? LINK : ID_Rd;
  load_use_detector #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_load_use (
    .ex_valid    (EX_Valid),
    .ex_memread  (EX_MemRead),
    .ex_writereg (EX_WriteReg),
    .id_valid    (ID_Valid),
    .id_rs       (ID_Rs),
    .id_rt       (ID_Rt),
    .id_usesrt   (ID_UsesRt),
    .hazard      (hazard)
  );
  assign Stall = Hold | (hazard & ~Flush);
  assign load  = ID_Valid & ~Flush & ~hazard;
  assign count = hazard & ~Flush & (BubbleCount != '1);
  // capture the ID bundle or a zeroed bubble; Hold freezes everything including the counter
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      ex_ctrl      <= BUBBLE_CTRL;
      EX_ReadData1 <= '0;
      EX_ReadData2 <= '0;
      EX_Imm       <= '0;
      EX_PCPlus4   <= '0;
      EX_Rs        <= '0;
      EX_Rt        <= '0;
      EX_Rd        <= '0;
      EX_WriteReg  <= '0;
      BubbleCount  <= '0;
    end else if (!Hold) begin
      ex_ctrl      <= load ? id_ctrl : BUBBLE_CTRL;
      EX_ReadData1 <= load ? ID_ReadData1 : '0;
      EX_ReadData2 <= load ? ID_ReadData2 : '0;
      EX_Imm       <= load ? ID_Imm : '0;
      EX_PCPlus4   <= load ? ID_PCPlus4 : '0;
      EX_Rs        <= load ? ID_Rs : '0;
      EX_Rt        <= load ? ID_Rt : '0;
      EX_Rd        <= load ? ID_Rd : '0;
      EX_WriteReg  <= load ? dest : '0;
      BubbleCount  <= BubbleCount + CNT_WIDTH'(count);
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed table-driven checks of the ID/EX register, hazard stall and bubble counter
module tb_id_ex_stage;
  typedef struct packed {
    logic v; logic [1:0] dst; logic rw, mr, as; logic [3:0] op;
    logic [4:0] rs, rt, rd; logic ur; logic [31:0] imm;
  } in_t;
  typedef struct packed {
    logic ev, erw, emr, eas; logic [4:0] ewr; logic [3:0] eop; logic [31:0] eimm;
  } ex_t;
  typedef struct packed {
    in_t i; logic fl, ho, st; ex_t x; logic [15:0] cnt; logic [1:0] cnt2;
  } vec_t;

  localparam in_t I_ADDI = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 4'd2, 5'd1, 5'd5, 5'd0, 1'b0, 32'h0000FFF0};
  localparam in_t I_LW   = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 4'd2, 5'd29, 5'd8, 5'd0, 1'b0, 32'd4};
  localparam in_t I_LW0  = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 4'd2, 5'd29, 5'd0, 5'd0, 1'b0, 32'd4};
  localparam in_t I_ADD  = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1, 5'd8, 5'd9, 5'd10, 1'b1, 32'd0};
  localparam in_t I_ADD0 = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1, 5'd0, 5'd9, 5'd10, 1'b1, 32'd0};
  localparam in_t I_ST   = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 4'd3, 5'd3, 5'd8, 5'd10, 1'b0, 32'd8};
  localparam in_t I_USE  = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1, 5'd3, 5'd8, 5'd10, 1'b1, 32'd0};
  localparam in_t I_JAL  = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 4'd4, 5'd0, 5'd0, 5'd0, 1'b0, 32'h100};
  localparam in_t I_INV  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1, 5'd8, 5'd9, 5'd10, 1'b1, 32'd0};
  localparam in_t I_RSV  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 4'd1, 5'd4, 5'd5, 5'd12, 1'b1, 32'd0};

  localparam ex_t X_BUB  = '0;
  localparam ex_t X_ADDI = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 4'd2, 32'h0000FFF0};
  localparam ex_t X_LW   = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 4'd2, 32'd4};
  localparam ex_t X_LW0  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 4'd2, 32'd4};
  localparam ex_t X_ADD  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 4'd1, 32'd0};
  localparam ex_t X_ST   = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 4'd3, 32'd8};
  localparam ex_t X_JAL  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 4'd4, 32'h100};
  localparam ex_t X_RSV  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 4'd1, 32'd0};

  logic Clk = 1'b0, Reset;
  logic ID_Valid, ID_RegWrite, ID_AluSrc, ID_MemWrite, ID_MemRead, ID_Branch, ID_Jump, ID_JumpMux, ID_UsesRt;
  logic [1:0] ID_RegDst, ID_MemToReg;
  logic [3:0] ID_AluOp;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PCPlus4;
  logic [4:0] ID_Rs, ID_Rt, ID_Rd;
  logic Flush, Hold;
  logic EX_Valid, EX_RegWrite, EX_AluSrc, EX_MemWrite, EX_MemRead, EX_Branch, EX_Jump, EX_JumpMux, Stall;
  logic [1:0] EX_RegDst, EX_MemToReg;
  logic [3:0] EX_AluOp;
  logic [31:0] EX_ReadData1, EX_ReadData2, EX_Imm, EX_PCPlus4;
  logic [4:0] EX_Rs, EX_Rt, EX_Rd, EX_WriteReg;
  logic [15:0] BubbleCount;
  logic b_Valid, b_RegWrite, b_AluSrc, b_MemWrite, b_MemRead, b_Branch, b_Jump, b_JumpMux, b_Stall;
  logic [1:0] b_RegDst, b_MemToReg;
  logic [3:0] b_AluOp;
  logic [31:0] b_ReadData1, b_ReadData2, b_Imm, b_PCPlus4;
  logic [4:0] b_Rs, b_Rt, b_Rd, b_WriteReg;
  logic [1:0] b_BubbleCount;

  int checks = 0, errs = 0;
  vec_t tbl[$];

  always #5 Clk = ~Clk;

  id_ex_stage dut (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_RegDst(ID_RegDst), .ID_MemToReg(ID_MemToReg),
    .ID_AluOp(ID_AluOp), .ID_RegWrite(ID_RegWrite), .ID_AluSrc(ID_AluSrc), .ID_MemWrite(ID_MemWrite),
    .ID_MemRead(ID_MemRead), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .ID_JumpMux(ID_JumpMux),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm), .ID_PCPlus4(ID_PCPlus4),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt), .Flush(Flush), .Hold(Hold),
    .EX_Valid(EX_Valid), .EX_RegDst(EX_RegDst), .EX_MemToReg(EX_MemToReg), .EX_AluOp(EX_AluOp),
    .EX_RegWrite(EX_RegWrite), .EX_AluSrc(EX_AluSrc), .EX_MemWrite(EX_MemWrite), .EX_MemRead(EX_MemRead),
    .EX_Branch(EX_Branch), .EX_Jump(EX_Jump), .EX_JumpMux(EX_JumpMux), .EX_ReadData1(EX_ReadData1),
    .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm), .EX_PCPlus4(EX_PCPlus4), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
    .EX_Rd(EX_Rd), .EX_WriteReg(EX_WriteReg), .Stall(Stall), .BubbleCount(BubbleCount)
  );

  id_ex_stage #(.CNT_WIDTH(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_RegDst(ID_RegDst), .ID_MemToReg(ID_MemToReg),
    .ID_AluOp(ID_AluOp), .ID_RegWrite(ID_RegWrite), .ID_AluSrc(ID_AluSrc), .ID_MemWrite(ID_MemWrite),
    .ID_MemRead(ID_MemRead), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .ID_JumpMux(ID_JumpMux),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm), .ID_PCPlus4(ID_PCPlus4),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt), .Flush(Flush), .Hold(Hold),
    .EX_Valid(b_Valid), .EX_RegDst(b_RegDst), .EX_MemToReg(b_MemToReg), .EX_AluOp(b_AluOp),
    .EX_RegWrite(b_RegWrite), .EX_AluSrc(b_AluSrc), .EX_MemWrite(b_MemWrite), .EX_MemRead(b_MemRead),
    .EX_Branch(b_Branch), .EX_Jump(b_Jump), .EX_JumpMux(b_JumpMux), .EX_ReadData1(b_ReadData1),
    .EX_ReadData2(b_ReadData2), .EX_Imm(b_Imm), .EX_PCPlus4(b_PCPlus4), .EX_Rs(b_Rs), .EX_Rt(b_Rt),
    .EX_Rd(b_Rd), .EX_WriteReg(b_WriteReg), .Stall(b_Stall), .BubbleCount(b_BubbleCount)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic ex_t snap();
    return '{EX_Valid, EX_RegWrite, EX_MemRead, EX_AluSrc, EX_WriteReg, EX_AluOp, EX_Imm};
  endfunction

  function automatic vec_t mk(input in_t i, input logic fl, input logic ho, input logic st,
                              input ex_t x, input logic [15:0] cnt, input logic [1:0] cnt2);
    return '{i, fl, ho, st, x, cnt, cnt2};
  endfunction

  task automatic drive(input in_t i, input logic fl, input logic ho);
    ID_Valid = i.v; ID_RegDst = i.dst; ID_RegWrite = i.rw; ID_MemRead = i.mr; ID_AluSrc = i.as;
    ID_AluOp = i.op; ID_Rs = i.rs; ID_Rt = i.rt; ID_Rd = i.rd; ID_UsesRt = i.ur; ID_Imm = i.imm;
    ID_MemToReg = {1'b0, i.mr}; ID_MemWrite = 1'b0; ID_Branch = 1'b0;
    ID_Jump = (i.dst == 2'b10); ID_JumpMux = 1'b0;
    ID_ReadData1 = i.imm ^ 32'hDEAD0000; ID_ReadData2 = 32'h12345678; ID_PCPlus4 = 32'h400;
    Flush = fl; Hold = ho;
  endtask

  initial begin
    tbl.push_back(mk(I_ADDI, 0, 0, 0, X_ADDI, 0, 0));
    tbl.push_back(mk(I_LW,   0, 0, 0, X_LW,   0, 0));
    tbl.push_back(mk(I_ADD,  0, 0, 1, X_BUB,  1, 1));
    tbl.push_back(mk(I_ADD,  0, 0, 0, X_ADD,  1, 1));
    tbl.push_back(mk(I_LW0,  0, 0, 0, X_LW0,  1, 1));
    tbl.push_back(mk(I_ADD0, 0, 0, 0, X_ADD,  1, 1));
    tbl.push_back(mk(I_LW,   0, 0, 0, X_LW,   1, 1));
    tbl.push_back(mk(I_ADD,  1, 0, 0, X_BUB,  1, 1));
    tbl.push_back(mk(I_LW,   0, 0, 0, X_LW,   1, 1));
    tbl.push_back(mk(I_ADD,  0, 1, 1, X_LW,   1, 1));
    tbl.push_back(mk(I_ADD,  0, 0, 1, X_BUB,  2, 2));
    tbl.push_back(mk(I_ADD,  0, 0, 0, X_ADD,  2, 2));
    tbl.push_back(mk(I_LW,   0, 0, 0, X_LW,   2, 2));
    tbl.push_back(mk(I_ADD,  0, 0, 1, X_BUB,  3, 3));
    tbl.push_back(mk(I_ADD,  0, 0, 0, X_ADD,  3, 3));
    tbl.push_back(mk(I_LW,   0, 0, 0, X_LW,   3, 3));
    tbl.push_back(mk(I_ADD,  0, 0, 1, X_BUB,  4, 3));
    tbl.push_back(mk(I_ADD,  0, 0, 0, X_ADD,  4, 3));
    tbl.push_back(mk(I_LW,   0, 0, 0, X_LW,   4, 3));
    tbl.push_back(mk(I_ADD,  0, 0, 1, X_BUB,  5, 3));
    tbl.push_back(mk(I_ADD,  0, 0, 0, X_ADD,  5, 3));
    tbl.push_back(mk(I_LW,   0, 0, 0, X_LW,   5, 3));
    tbl.push_back(mk(I_ST,   0, 0, 0, X_ST,   5, 3));
    tbl.push_back(mk(I_LW,   0, 0, 0, X_LW,   5, 3));
    tbl.push_back(mk(I_USE,  0, 0, 1, X_BUB,  6, 3));
    tbl.push_back(mk(I_USE,  0, 0, 0, X_ADD,  6, 3));
    tbl.push_back(mk(I_JAL,  0, 0, 0, X_JAL,  6, 3));
    tbl.push_back(mk(I_INV,  0, 0, 0, X_BUB,  6, 3));
    tbl.push_back(mk(I_RSV,  0, 0, 0, X_RSV,  6, 3));
    tbl.push_back(mk(I_ADD,  0, 1, 1, X_RSV,  6, 3));
    tbl.push_back(mk(I_ADD,  0, 0, 0, X_ADD,  6, 3));
    tbl.push_back(mk(I_LW,   1, 0, 0, X_BUB,  6, 3));

    drive(I_INV, 0, 0);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_ex", 64'(snap()), 64'(X_BUB));
    chk("reset_cnt", 64'(BubbleCount), 64'd0);
    chk("reset_stall", 64'(Stall), 64'd0);
    Reset = 1'b0;
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].i, tbl[k].fl, tbl[k].ho);
      #1;
      chk($sformatf("v%0d_stall", k), 64'(Stall), 64'(tbl[k].st));
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d_ex", k), 64'(snap()), 64'(tbl[k].x));
      chk($sformatf("v%0d_cnt", k), 64'(BubbleCount), 64'(tbl[k].cnt));
      chk($sformatf("v%0d_cnt2", k), 64'(b_BubbleCount), 64'(tbl[k].cnt2));
    end

    drive(I_LW, 0, 0);
    @(posedge Clk);
    #1;
    chk("pre_rst_rw", 64'(EX_RegWrite), 64'd1);
    chk("pre_rst_rd1", 64'(EX_ReadData1), 64'(32'hDEAD0004));
    drive(I_ADD, 0, 0);
    #1;
    chk("pre_rst_stall", 64'(Stall), 64'd1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_stall", 64'(Stall), 64'd0);
    chk("mid_rst_ex", 64'(snap()), 64'(X_BUB));
    chk("mid_rst_cnt", 64'(BubbleCount), 64'd0);
    chk("mid_rst_cnt2", 64'(b_BubbleCount), 64'd0);
    chk("mid_rst_data", 64'({EX_ReadData1, EX_PCPlus4}), 64'd0);
    chk("mid_rst_misc", 64'({EX_RegDst, EX_MemToReg, EX_Rs, EX_Rt, EX_Rd}), 64'd0);
    Reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the decode stage (opcode decoder plus register file read) and the execute stage of the MIPS datapath.
- Captures the decoder control bundle and the operands, and computes the destination register.
- Detects load-use hazards: asserts Stall and inserts a bubble.
- Supports flush (taken branch/jump), external hold, and a saturating bubble counter for performance measurement.

Parameters:
- DATA_WIDTH, 32, width of operand, immediate and PC paths
- REG_ADDR_WIDTH, 5, register specifier width
- CNT_WIDTH, 16, BubbleCount width
- LINK_REG, 31, destination register when RegDst=2'b10 (JAL)

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- ID_Valid  input  1  decode slot holds a real instruction
- ID_RegDst  input  2  00=Rd, 01=Rt, 10=LINK_REG, 11=reserved (treated as Rd)
- ID_MemToReg  input  2  writeback source select
- ID_AluOp  input  4  ALU-controller opcode
- ID_RegWrite, ID_AluSrc, ID_MemWrite, ID_MemRead, ID_Branch, ID_Jump, ID_JumpMux  input  1 each  decoder controls
- ID_ReadData1, ID_ReadData2, ID_Imm, ID_PCPlus4  input  DATA_WIDTH each  operands; Imm already extended
- ID_Rs, ID_Rt, ID_Rd  input  REG_ADDR_WIDTH each  specifiers
- ID_UsesRt  input  1  instruction reads Rt as a source
- Flush  input  1  kill the instruction currently entering EX
- Hold  input  1  downstream busy; freeze this stage
- EX_<x>  output  same width as ID_<x>  registered copy for every ID_ input above except ID_UsesRt
- EX_WriteReg  output  REG_ADDR_WIDTH  registered resolved destination; 0 when RegWrite=0
- Stall  output  1  combinational; freeze the PC and the IF/ID register
- BubbleCount  output  CNT_WIDTH  saturating count of hazard bubbles

Behaviour:
- All EX_* outputs, EX_WriteReg and BubbleCount are registered on the rising edge of Clk.
- Latency is 1 cycle from ID to EX.
- Reset (async, high): every EX_* output, EX_WriteReg and BubbleCount go to 0 immediately. EX_Valid=0 and AluOp=4'b0000.
- Bubble: EX_Valid, RegWrite, MemWrite, MemRead, Branch, Jump, JumpMux, EX_WriteReg all 0. Data fields are don't-care but are driven to 0.
- Hazard (combinational) = EX_Valid & EX_MemRead & (EX_WriteReg!=0) & ID_Valid & (EX_WriteReg==ID_Rs | (ID_UsesRt & EX_WriteReg==ID_Rt)).
- Stall = Hold | (Hazard & ~Flush).
- Next-state priority at each edge:
  1. Hold: all registers keep their value, including BubbleCount.
  2. Flush: load a bubble.
  3. Hazard: load a bubble; BubbleCount += 1, saturating at all-ones.
  4. ID_Valid=0: load a bubble.
  5. Otherwise: load the ID_ bundle; EX_WriteReg = mux(ID_RegDst), forced to 0 if ID_RegWrite=0.
- A write to $0 never creates a hazard.
- A hazard lasts exactly one cycle. After the bubble, the load in EX has moved on, so Hazard drops and the held ID instruction is captured on the next edge.
- Simultaneous Hold and Hazard: freeze only; no bubble and no count. The hazard is re-evaluated after Hold drops.
- Simultaneous Flush and Hazard: bubble, Stall=0, no count.
- Reset mid-stall releases Stall immediately, because EX_Valid=0.

Decomposition:
- Shared package holds:
  - RegDst encodings (REGDST_RD, REGDST_RT, REGDST_LINK)
  - MemToReg encodings
  - AluOp constants, including ALUOP_NOP=4'b0000
  - the bubble control-bundle constant
- One natural sub-module: load_use_detector, purely combinational, producing Hazard from the EX_ and ID_ fields.

Test Plan:
- Reset asserted mid-cycle with EX_RegWrite=1 -> all outputs 0 immediately without a clock edge; BubbleCount=0.
- ADDI with Rt=5, RegDst=01, ID_Imm=0x0000FFF0 -> next edge: EX_WriteReg=5, EX_AluSrc=1, EX_Imm=0x0000FFF0, Stall=0.
- LW with Rt=8, then ADD with Rs=8 -> Stall=1 for one cycle, one bubble (EX_Valid=0), BubbleCount=1; ADD reaches EX one cycle later.
- LW with Rt=0, then ADD with Rs=0 -> no stall, BubbleCount unchanged.
- LW with Rt=8 in EX, ADD with Rs=8 in ID, Flush=1 and Hold=0 -> Stall=0, bubble loaded, BubbleCount unchanged. Repeat with Hold=1 -> registers frozen, Stall=1.
- CNT_WIDTH=2: five load-use pairs -> BubbleCount saturates at 3. JAL (RegDst=10, RegWrite=1) -> EX_WriteReg=31.
